// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART byte output and the CPU I/O read bus.
// Latency: a byte pushed on edge N can be popped by an io_rd on edge N+1; io_dout is valid one cycle after io_rd.
// Backpressure: none upstream. A byte arriving into a full buffer is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   rx_data/valid   one-cycle byte strobe from the UART receiver
//   io_rd/io_addr   CPU read strobe; addr 0 = data (pop), 1 = status, 2 = count (optional), 3 = reserved
//   io_dout         registered read data, holds its value when io_rd = 0
//   rx_ready        at least one byte buffered
//   full            DEPTH bytes buffered
// Optional: define UART_RX_FIFO_COUNT_EN to make address 2 return the fill count.
// Status word layout: bit 2 = overflow, bit 1 = full, bit 0 = rx_ready.
module uart_rx_fifo #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              io_rd,
  input  logic [1:0]        io_addr,
  output logic [DATA_W-1:0] io_dout,
  output logic              rx_ready,
  output logic              full
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (DATA_W < 3) begin : g_bad_width
    $error("uart_rx_fifo: DATA_W must be at least 3 to hold the status word");
  end
`ifdef UART_RX_FIFO_COUNT_EN
  if (DEPTH > (2**DATA_W) - 1) begin : g_bad_cnt
    $error("uart_rx_fifo: count readback needs DEPTH <= 2**DATA_W - 1");
  end
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] io_dout_q, io_dout_d;

  logic rd_data, rd_stat, pop, push, drop;

  assign rx_ready = (count_q != '0);
  assign full     = (count_q == CNT_FULL);
  assign io_dout  = io_dout_q;

  always_comb begin
    rd_data = io_rd && (io_addr == 2'd0);
    rd_stat = io_rd && (io_addr == 2'd1);
    pop     = rd_data && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push    = rx_valid && ((count_q != CNT_FULL) || pop);
    drop    = rx_valid && !push;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set wins over the read-to-clear of a status access.
    overflow_d = drop || (overflow_q && !rd_stat);

    io_dout_d = io_dout_q;
    if (io_rd) begin
      io_dout_d = '0;
      case (io_addr)
        2'd0: if (pop) io_dout_d = mem_q[rd_ptr_q];
        2'd1: io_dout_d[2:0] = {overflow_q, full, rx_ready};
`ifdef UART_RX_FIFO_COUNT_EN
        2'd2: io_dout_d[AW:0] = count_q;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      io_dout_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      io_dout_q  <= io_dout_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule
